// File: rtl/bist_pkg.sv
// Shared definitions for the benchmark BIST controller: FSM states, LFSR taps,
// MISR polynomials and a popcount helper.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Feedback masks for maximal-length shift-left Fibonacci LFSRs (bit i = q[i] tapped).
  function automatic logic [15:0] lfsr_taps(input int n);
    case (n)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0003;
    endcase
  endfunction

  function automatic logic [31:0] misr_poly(input int w);
    case (w)
      8:       return 32'h0000_0007;
      16:      return 32'h0000_1021;
      24:      return 32'h005D_6DCB;
      32:      return 32'h04C1_1DB7;
      default: return 32'h0000_0003;
    endcase
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/bench_bist_ctrl_lfsr.sv
// Pattern generator: loadable shift-left Fibonacci LFSR; an all-zero seed becomes 1.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int N_IN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            enable,
  input  logic [N_IN-1:0] seed,
  output logic [N_IN-1:0] q
);

  localparam logic [N_IN-1:0] TAP_MASK = N_IN'(lfsr_taps(N_IN));
  localparam logic [N_IN-1:0] ONE      = {{(N_IN-1){1'b0}}, 1'b1};

  logic fb;

  assign fb = ^(q & TAP_MASK);

  always_ff @(posedge clk) begin
    if (rst)         q <= '0;
    else if (load)   q <= (seed == '0) ? ONE : seed;
    else if (enable) q <= {q[N_IN-2:0], fb};
  end

endmodule

// File: rtl/bench_bist_ctrl.sv
// BIST harness for one combinational netlist: drives LFSR patterns, compacts
// responses into a MISR signature and counts input/output toggles.
module bench_bist_ctrl
  import bist_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int N_OUT = 2,
  parameter int N_PAT = 31,
  parameter int SIG_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_IN-1:0]  seed,
  output logic [N_IN-1:0]  pat_out,
  output logic             pat_valid,
  input  logic [N_OUT-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] in_tgl,
  output logic [CNT_W-1:0] out_tgl,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam logic [SIG_W-1:0] POLY     = SIG_W'(misr_poly(SIG_W));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PAT - 1);
  localparam int               CW1      = CNT_W + 1;

  state_t           state, state_next;
  logic [N_IN-1:0]  prev_pat;
  logic [N_OUT-1:0] prev_resp;
  logic             accept, last_pat;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [N_OUT-1:0] r);
    logic [SIG_W-1:0] fbv;
    fbv = s[SIG_W-1] ? POLY : '0;
    return {s[SIG_W-2:0], 1'b0} ^ fbv ^ SIG_W'(r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [4:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + CW1'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign accept    = (state == ST_IDLE) && start;
  assign last_pat  = (pat_cnt == LAST_CNT);
  assign pat_valid = (state == ST_RUN);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign done      = (state == ST_DONE);

  // The LFSR stops on the final pattern so pat_out keeps showing it afterwards.
  bist_lfsr #(.N_IN(N_IN)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .enable ((state == ST_RUN) && !last_pat),
    .seed   (seed),
    .q      (pat_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)    state_next = ST_RUN;
      ST_RUN:  if (last_pat) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      signature <= '0;
      in_tgl    <= '0;
      out_tgl   <= '0;
      pat_cnt   <= '0;
      prev_pat  <= '0;
      prev_resp <= '0;
    end else if (state == ST_RUN) begin
      signature <= misr_step(signature, resp_in);
      in_tgl    <= sat_add(in_tgl, popcount(16'(pat_out ^ prev_pat)));
      out_tgl   <= sat_add(out_tgl, popcount(16'(resp_in ^ prev_resp)));
      pat_cnt   <= sat_add(pat_cnt, 5'd1);
      prev_pat  <= pat_out;
      prev_resp <= resp_in;
    end
  end

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// Scoreboard bench for bench_bist_ctrl: random seeds and response tables
// against a behavioural model of the pattern/signature/toggle rules.
module tb_bench_bist_ctrl;

  localparam int NP = 31;

  typedef struct {
    int sig;
    int itg;
    int otg;
    int cnt;
    int last;
    int done_idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic [4:0]  seed, seed1;
  logic [4:0]  pat_out, pat_out1;
  logic        pat_valid, pat_valid1, busy, busy1, done, done1;
  logic [1:0]  resp, resp1;
  logic [15:0] signature, signature1, in_tgl, in_tgl1, out_tgl, out_tgl1, pat_cnt, pat_cnt1;

  logic [1:0]  tbl [32];
  int          pat_q [$];
  exp_t        res_q [$];
  bit          seen [32];
  bit          dup;
  int          ncnt = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        mon_e;
  int          mon_p;

  always #5 clk = ~clk;

  assign resp  = tbl[pat_out];
  assign resp1 = 2'b01;

  bench_bist_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .pat_out(pat_out),
    .pat_valid(pat_valid), .resp_in(resp), .busy(busy), .done(done),
    .signature(signature), .in_tgl(in_tgl), .out_tgl(out_tgl), .pat_cnt(pat_cnt)
  );

  bench_bist_ctrl #(.N_PAT(1)) u_one (
    .clk(clk), .rst(rst), .start(start1), .seed(seed1), .pat_out(pat_out1),
    .pat_valid(pat_valid1), .resp_in(resp1), .busy(busy1), .done(done1),
    .signature(signature1), .in_tgl(in_tgl1), .out_tgl(out_tgl1), .pat_cnt(pat_cnt1)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, g10, g11, g16, g19, g22, g23;
    {n7, n6, n3, n2, n1} = v;
    g10 = !(n1 & n3);
    g11 = !(n3 & n6);
    g16 = !(n2 & g11);
    g19 = !(g11 & n7);
    g22 = !(g10 & g16);
    g23 = !(g16 & g19);
    return {g23, g22};
  endfunction

  // mode 0: all-zero responses, 1: constant 2'b11, 2: C17 netlist, 3: random table
  task automatic set_tbl(input int mode);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       tbl[i] = 2'b00;
        1:       tbl[i] = 2'b11;
        2:       tbl[i] = c17(5'(i));
        default: tbl[i] = 2'($urandom);
      endcase
    end
  endtask

  // Reference: maximal-length sequence x^5+x^3+1, CRC-style MISR, toggle popcounts.
  task automatic model(input logic [4:0] sd, output exp_t e);
    int v, s, it, ot, pp, pr, r;
    v = (sd == 5'd0) ? 1 : int'(sd);
    s = 0; it = 0; ot = 0; pp = 0; pr = 0;
    e.last = 0;
    for (int k = 0; k < NP; k++) begin
      pat_q.push_back(v);
      r  = int'(tbl[v]);
      s  = ((s << 1) & 'hFFFF) ^ ((((s >> 15) & 1) != 0) ? 'h1021 : 0) ^ r;
      it += $countones(v ^ pp);
      ot += $countones(r ^ pr);
      pp = v; pr = r; e.last = v;
      v  = ((v << 1) & 'h1F) | (((v >> 4) ^ (v >> 2)) & 1);
    end
    e.sig = s; e.itg = it; e.otg = ot; e.cnt = NP;
    e.done_idx = ncnt + 2 + NP;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pat_out"}, pat_out, 0);
    chk({tag, "_pat_valid"}, pat_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_signature"}, signature, 0);
    chk({tag, "_in_tgl"}, in_tgl, 0);
    chk({tag, "_out_tgl"}, out_tgl, 0);
    chk({tag, "_pat_cnt"}, pat_cnt, 0);
  endtask

  task automatic run(input logic [4:0] sd, input bit pulses, input bit abort);
    exp_t e;
    @(posedge clk); #1;
    model(sd, e);
    res_q.push_back(e);
    seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed = 5'($urandom);
    if (abort) begin
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pat_q.delete(); res_q.delete();
      foreach (seen[i]) seen[i] = 1'b0;
      dup = 1'b0;
      check_zero("abort");
      repeat (NP + 4) @(posedge clk);
    end else begin
      if (pulses) begin
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 start = 1'b1;   // lands in the DONE cycle
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
      end else begin
        repeat (NP + 4) @(posedge clk);
      end
      #1;
      chk("hold_pat_valid", pat_valid, 0);
      chk("hold_busy", busy, 0);
      chk("hold_done", done, 0);
      chk("hold_signature", signature, e.sig);
      chk("hold_in_tgl", in_tgl, e.itg);
      chk("hold_out_tgl", out_tgl, e.otg);
      chk("hold_pat_cnt", pat_cnt, e.cnt);
      chk("hold_pat_out", pat_out, e.last);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a pattern or a done pulse.
  always @(negedge clk) begin
    ncnt = ncnt + 1;
    if (pat_valid) begin
      if (pat_q.size() == 0) begin
        chk("unexpected_pattern", pat_valid, 0);
      end else begin
        mon_p = pat_q.pop_front();
        chk("pat_out", pat_out, mon_p);
        if (pat_out == 5'd0 || seen[pat_out]) dup = 1'b1;
        seen[pat_out] = 1'b1;
      end
    end
    if (done) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        mon_e = res_q.pop_front();
        chk("signature", signature, mon_e.sig);
        chk("in_tgl", in_tgl, mon_e.itg);
        chk("out_tgl", out_tgl, mon_e.otg);
        chk("pat_cnt", pat_cnt, mon_e.cnt);
        chk("done_cycle", ncnt, mon_e.done_idx);
        chk("busy_in_done", busy, 1);
        chk("distinct_nonzero", dup, 0);
      end
      foreach (seen[i]) seen[i] = 1'b0;
      dup = 1'b0;
    end
  end

  initial begin
    logic [4:0] sd;
    int nd;
    rst = 1'b1; start = 1'b0; seed = '0; start1 = 1'b0; seed1 = '0; dup = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    set_tbl(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    run(5'd1, 1'b0, 1'b0);
    run(5'd0, 1'b0, 1'b0);
    set_tbl(1);
    run(5'($urandom), 1'b0, 1'b0);
    set_tbl(2);
    run(5'($urandom), 1'b1, 1'b0);

    set_tbl(3);
    sd = 5'($urandom);
    run(sd, 1'b0, 1'b1);
    run(sd, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_tbl(3);
      run(5'($urandom), i[0], 1'b0);
    end

    // Single-pattern instance with a constant 2'b01 response.
    @(posedge clk); #1;
    seed1 = 5'b10110; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (done1) nd++;
      @(posedge clk); #1;
    end
    chk("one_done_pulses", nd, 1);
    chk("one_signature", signature1, 1);
    chk("one_pat_cnt", pat_cnt1, 1);
    chk("one_out_tgl", out_tgl1, 1);
    chk("one_in_tgl", in_tgl1, 3);
    chk("one_pat_out", pat_out1, 5'b10110);

    chk("pending_patterns", pat_q.size(), 0);
    chk("pending_results", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
